// File: rtl/edge_detector_mc.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter,
// selectable rise/fall/both edge pulse, sticky software-clearable flag and irq.
module edge_detector_mc #(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_CH-1:0]   din,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH-1:0]   dout,
  output logic [N_CH-1:0]   level,
  output logic [N_CH-1:0]   flag,
  output logic              irq
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_r;
  logic [N_CH-1:0]                  sync_s;
  logic [N_CH-1:0]                  stab_r;
  logic [N_CH-1:0]                  stab_nx_s;
  logic [CNT_W-1:0]                 cnt_r    [N_CH];
  logic [CNT_W-1:0]                 cnt_nx_s [N_CH];
  logic [N_CH-1:0]                  ev_r;
  logic [N_CH-1:0]                  ev_nx_s;
  logic [N_CH-1:0]                  dout_r;
  logic [N_CH-1:0]                  flag_r;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous inputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_r <= '0;
    end else begin
      sync_r[0] <= din;
      for (int j = 1; j < SYNC_STAGES; j++) begin
        sync_r[j] <= sync_r[j-1];
      end
    end
  end

  // Filter next state and edge qualification; mode is sampled here, on the
  // same edge at which the stable level updates.
  always_comb begin
    stab_nx_s = stab_r;
    ev_nx_s   = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_nx_s[i] = '0;
      if (sync_s[i] == stab_r[i]) begin
        cnt_nx_s[i] = '0;
      end else if (cnt_r[i] == CNT_TERM) begin
        stab_nx_s[i] = sync_s[i];
        cnt_nx_s[i]  = '0;
      end else begin
        cnt_nx_s[i] = cnt_r[i] + CNT_ONE;
      end
      ev_nx_s[i] = (stab_nx_s[i] & ~stab_r[i] & mode[2*i]) |
                   (~stab_nx_s[i] & stab_r[i] & mode[2*i+1]);
    end
  end

  // Filter state, pending event, pulse and sticky flag registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stab_r <= '0;
      ev_r   <= '0;
      dout_r <= '0;
      flag_r <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      stab_r <= stab_nx_s;
      ev_r   <= ev_nx_s;
      dout_r <= ev_r;
      // A new event wins over a clear on the same edge
      flag_r <= (flag_r & ~clr) | ev_r;
      for (int i = 0; i < N_CH; i++) begin
        cnt_r[i] <= cnt_nx_s[i];
      end
    end
  end

  assign level = stab_r;
  assign dout  = dout_r;
  assign flag  = flag_r;
  assign irq   = |flag_r;

endmodule

// File: tb/tb_edge_detector_mc.sv
// Scoreboard bench for edge_detector_mc: default instance (FILTER_CYCLES=1)
// and a FILTER_CYCLES=4 instance, each with its own expected-pulse queue.
module tb_edge_detector_mc;

  typedef struct {
    int         t;
    logic [3:0] m;
  } exp_t;

  logic       clk;
  logic       resetn_a, resetn_b;
  logic [3:0] din_a, din_b, clr_a, clr_b;
  logic [7:0] mode_a, mode_b;
  logic [3:0] dout_a, level_a, flag_a, dout_b, level_b, flag_b;
  logic       irq_a, irq_b;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   e;
  exp_t qa[$];
  exp_t qb[$];
  logic [3:0] ma, mb;

  edge_detector_mc #(.N_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(1)) dut_a (
    .clk(clk), .resetn(resetn_a), .din(din_a), .mode(mode_a), .clr(clr_a),
    .dout(dout_a), .level(level_a), .flag(flag_a), .irq(irq_a)
  );

  edge_detector_mc #(.N_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(4)) dut_b (
    .clk(clk), .resetn(resetn_b), .din(din_b), .mode(mode_b), .clr(clr_b),
    .dout(dout_b), .level(level_b), .flag(flag_b), .irq(irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%b required=%b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for instance A: every pulse must match the head of its queue
  always @(negedge clk) begin
    if (resetn_a) begin
      if (qa.size() > 0 && qa[0].t < cyc) begin
        total++; bad++;
        $display("FAIL pulse_a_missed: actual=none required=%b at cycle %0d", qa[0].m, qa[0].t);
        void'(qa.pop_front());
      end
      if (dout_a != 4'b0000 || (qa.size() > 0 && qa[0].t == cyc)) begin
        ma = 4'b0000;
        if (qa.size() > 0 && qa[0].t == cyc) begin
          ma = qa[0].m;
          void'(qa.pop_front());
        end
        total++;
        if (dout_a !== ma) begin
          bad++;
          $display("FAIL pulse_a: actual=%b required=%b at cycle %0d", dout_a, ma, cyc);
        end
      end
    end
  end

  // Monitor for instance B
  always @(negedge clk) begin
    if (resetn_b) begin
      if (qb.size() > 0 && qb[0].t < cyc) begin
        total++; bad++;
        $display("FAIL pulse_b_missed: actual=none required=%b at cycle %0d", qb[0].m, qb[0].t);
        void'(qb.pop_front());
      end
      if (dout_b != 4'b0000 || (qb.size() > 0 && qb[0].t == cyc)) begin
        mb = 4'b0000;
        if (qb.size() > 0 && qb[0].t == cyc) begin
          mb = qb[0].m;
          void'(qb.pop_front());
        end
        total++;
        if (dout_b !== mb) begin
          bad++;
          $display("FAIL pulse_b: actual=%b required=%b at cycle %0d", dout_b, mb, cyc);
        end
      end
    end
  end

  initial begin
    resetn_a = 1'b0; resetn_b = 1'b0;
    din_a = 4'b0; din_b = 4'b0; clr_a = 4'b0; clr_b = 4'b0;
    mode_a = 8'h00; mode_b = 8'h00;
    tick(3);
    chk("reset_level", level_a, 4'b0000);
    chk("reset_dout", dout_a, 4'b0000);
    chk("reset_flag", flag_a, 4'b0000);
    chk("reset_irq", {3'b000, irq_a}, 4'b0000);
    resetn_a = 1'b1; resetn_b = 1'b1;
    tick(5);

    // Rise on ch0: level after 3 negedges, pulse on the 4th
    mode_a = 8'h01;
    e = cyc; din_a[0] = 1'b1; qa.push_back(exp_t'{e + 4, 4'b0001});
    tick(2); chk("rise_level_early", level_a, 4'b0000);
    tick(1); chk("rise_level", level_a, 4'b0001);
    tick(1); chk("rise_flag", flag_a, 4'b0001);
    chk("rise_irq", {3'b000, irq_a}, 4'b0001);
    tick(1); chk("rise_dout_one_cycle", dout_a, 4'b0000);

    // Flag clear, then clear colliding with a new event
    clr_a = 4'b0001; tick(1); clr_a = 4'b0000;
    chk("clr_flag", flag_a, 4'b0000);
    chk("clr_irq", {3'b000, irq_a}, 4'b0000);
    mode_a = 8'h03;
    e = cyc; din_a[0] = 1'b0; qa.push_back(exp_t'{e + 4, 4'b0001});
    tick(3); clr_a = 4'b0001; tick(1); clr_a = 4'b0000;
    chk("set_wins_flag", flag_a, 4'b0001);
    clr_a = 4'b0001; tick(1); clr_a = 4'b0000;
    chk("clr_after_set", flag_a, 4'b0000);
    chk("clr_after_set_irq", {3'b000, irq_a}, 4'b0000);
    clr_a = 4'b0001; tick(1); clr_a = 4'b0000;
    chk("clr_idle", flag_a, 4'b0000);

    // Fall on ch1, both edges on ch2, ch0/ch3 off
    mode_a = 8'h38;
    e = cyc; din_a = 4'b0110; qa.push_back(exp_t'{e + 4, 4'b0100});
    tick(20);
    e = cyc; din_a = 4'b0000; qa.push_back(exp_t'{e + 4, 4'b0110});
    tick(6);
    chk("fallboth_flag", flag_a, 4'b0110);
    chk("fallboth_level", level_a, 4'b0000);
    clr_a = 4'b1111; tick(1); clr_a = 4'b0000;

    // Back-to-back transitions on ch0, one pulse per cycle
    mode_a = 8'h03;
    e = cyc;
    din_a[0] = 1'b1; qa.push_back(exp_t'{e + 4, 4'b0001}); tick(1);
    din_a[0] = 1'b0; qa.push_back(exp_t'{e + 5, 4'b0001}); tick(1);
    din_a[0] = 1'b1; qa.push_back(exp_t'{e + 6, 4'b0001}); tick(1);
    din_a[0] = 1'b0; qa.push_back(exp_t'{e + 7, 4'b0001});
    tick(6);
    chk("b2b_level", level_a, 4'b0000);
    clr_a = 4'b1111; tick(1); clr_a = 4'b0000;

    // Mode off on ch3 tracks level silently, then rise-only mode
    mode_a = 8'h00;
    din_a[3] = 1'b1; tick(3);
    chk("off_level_hi", level_a, 4'b1000);
    tick(3); chk("off_flag", flag_a, 4'b0000);
    din_a[3] = 1'b0; tick(4);
    chk("off_level_lo", level_a, 4'b0000);
    mode_a = 8'h40;
    e = cyc; din_a[3] = 1'b1; qa.push_back(exp_t'{e + 4, 4'b1000});
    tick(8); din_a[3] = 1'b0; tick(8);
    chk("reconf_flag", flag_a, 4'b1000);
    chk("reconf_level", level_a, 4'b0000);

    // din held high through reset release is a rise
    resetn_a = 1'b0; din_a[0] = 1'b1; mode_a = 8'h01;
    tick(2);
    chk("rst_flag", flag_a, 4'b0000);
    e = cyc; resetn_a = 1'b1; qa.push_back(exp_t'{e + 4, 4'b0001});
    tick(8);
    chk("powerup_level", level_a, 4'b0001);

    // FILTER_CYCLES=4: 3-cycle glitch rejected, 4-cycle pulse accepted
    mode_b = 8'h01;
    din_b[0] = 1'b1; tick(3); din_b[0] = 1'b0; tick(10);
    chk("glitch_level", level_b, 4'b0000);
    chk("glitch_flag", flag_b, 4'b0000);
    e = cyc; din_b[0] = 1'b1; qb.push_back(exp_t'{e + 7, 4'b0001});
    tick(4); din_b[0] = 1'b0;
    tick(1); chk("filt_level_early", level_b, 4'b0000);
    tick(1); chk("filt_level", level_b, 4'b0001);
    tick(1); chk("filt_flag", flag_b, 4'b0001);
    tick(12); chk("filt_level_back", level_b, 4'b0000);

    // Async reset mid-filter aborts everything
    din_b[0] = 1'b1; tick(4);
    #2 resetn_b = 1'b0; din_b[0] = 1'b0;
    #1;
    chk("midrst_level", level_b, 4'b0000);
    chk("midrst_dout", dout_b, 4'b0000);
    chk("midrst_flag", flag_b, 4'b0000);
    chk("midrst_irq", {3'b000, irq_b}, 4'b0000);
    tick(2); resetn_b = 1'b1;
    tick(15);
    chk("postrst_level", level_b, 4'b0000);
    chk("postrst_flag", flag_b, 4'b0000);

    tick(2);
    chk("qa_drained", 4'(qa.size()), 4'b0000);
    chk("qb_drained", 4'(qb.size()), 4'b0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
